otter_pc_fetch: RTL and testbench

//  Program counter and instruction-fetch stage, directly downstream of the branch condition generator.
//  - Holds PC and issues one instruction-memory read at a time; single outstanding request.
//  - Presents the fetched instruction to decode through a valid/ready handshake.
//  - On decode acceptance, selects next PC from pcSource (0 pc+4, 1 jalr, 2 branch, 3 jal, 4 mtvec, 5 mepc).

---
 rtl/otter_pkg.sv | 6 +
 rtl/otter_next_pc_mux.sv | 28 ++
 rtl/otter_pc_fetch.sv | 79 +++++++
 tb/tb_otter_pc_fetch.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/otter_pkg.sv
// otter_pkg: shared types and constants for the OTTER fetch stage
package otter_pkg;
  typedef enum logic [2:0] {PC_SEQ, PC_JALR, PC_BR, PC_JAL, PC_MTVEC, PC_MEPC} pc_src_t;
  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_WAIT, ST_HOLD} fetch_state_t;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
endpackage

// File: rtl/otter_next_pc_mux.sv
// otter_next_pc_mux: selects the next PC from pcSource and forces word alignment
module otter_next_pc_mux
  import otter_pkg::*;
(
  input  logic [2:0]  pc_source,
  input  logic [31:0] pc_plus4,
  input  logic [31:0] jalr_target,
  input  logic [31:0] branch_target,
  input  logic [31:0] jal_target,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  output logic [31:0] next_pc
);
  logic [31:0] sel;
  // Reserved encodings 6/7 fall through to sequential; low bits cleared for jalr alignment
  always_comb begin
    sel = pc_plus4;
    case (pc_src_t'(pc_source))
      PC_JALR:  sel = jalr_target;
      PC_BR:    sel = branch_target;
      PC_JAL:   sel = jal_target;
      PC_MTVEC: sel = mtvec;
      PC_MEPC:  sel = mepc;
      default:  sel = pc_plus4;
    endcase
    next_pc = {sel[31:2], 2'b00};
  end
endmodule

// File: rtl/otter_pc_fetch.sv
// otter_pc_fetch: program counter and single-outstanding instruction fetch with decode handshake
module otter_pc_fetch
  import otter_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] PC_INC    = 32'd4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [2:0]  pcSource,
  input  logic [31:0] jalr_target,
  input  logic [31:0] branch_target,
  input  logic [31:0] jal_target,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] ir,
  output logic        ir_valid,
  input  logic        ir_ready
);
  fetch_state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, next_pc;

  assign pc        = pc_q;
  assign pc_plus4  = pc_q + PC_INC;
  assign imem_addr = pc_q;
  assign ir        = ir_q;
  assign imem_req  = state_q == ST_FETCH;
  assign ir_valid  = state_q == ST_HOLD;

  otter_next_pc_mux u_mux (
    .pc_source    (pcSource),
    .pc_plus4     (pc_plus4),
    .jalr_target  (jalr_target),
    .branch_target(branch_target),
    .jal_target   (jal_target),
    .mtvec        (mtvec),
    .mepc         (mepc),
    .next_pc      (next_pc)
  );

  // Fetch sequencing: request, await data, hold for decode, then advance PC on accept
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      ST_IDLE:  state_d = ST_FETCH;
      ST_FETCH: state_d = imem_gnt ? ST_WAIT : ST_FETCH;
      ST_WAIT: begin
        ir_d    = imem_rvalid ? imem_rdata : ir_q;
        state_d = imem_rvalid ? ST_HOLD : ST_WAIT;
      end
      default: begin
        pc_d    = ir_ready ? next_pc : pc_q;
        state_d = ir_ready ? ST_FETCH : ST_HOLD;
      end
    endcase
  end

  // State, PC and instruction registers; reset aborts any transaction in flight
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_VEC;
      ir_q    <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end
endmodule

// File: tb/tb_otter_pc_fetch.sv
// tb_otter_pc_fetch: randomized self-checking bench against a behavioural fetch model
module tb_otter_pc_fetch;
  logic        CLK = 0, RST = 1;
  logic [2:0]  pcSource = 0;
  logic [31:0] jalr_target = 0, branch_target = 0, jal_target = 0, mtvec = 0, mepc = 0;
  logic        imem_req, imem_gnt = 0, imem_rvalid = 0, ir_valid, ir_ready = 0;
  logic [31:0] imem_addr, imem_rdata = 0, pc, pc_plus4, ir;
  int checks = 0, errors = 0;
  logic [31:0] exp_pc = 0;

  otter_pc_fetch dut (
    .CLK(CLK), .RST(RST), .pcSource(pcSource),
    .jalr_target(jalr_target), .branch_target(branch_target), .jal_target(jal_target),
    .mtvec(mtvec), .mepc(mepc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .pc(pc), .pc_plus4(pc_plus4), .ir(ir), .ir_valid(ir_valid), .ir_ready(ir_ready)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h0000_0013;
  endfunction

  // Architectural rule: choose target by source, reserved codes sequential, word aligned
  function automatic logic [31:0] model_next(input logic [2:0] s, input logic [31:0] p);
    logic [31:0] t;
    t = (s == 1) ? jalr_target : (s == 2) ? branch_target : (s == 3) ? jal_target :
        (s == 4) ? mtvec : (s == 5) ? mepc : p + 32'd4;
    return t & 32'hFFFF_FFFC;
  endfunction

  task automatic wait_req();
    int i;
    for (i = 0; i < 20 && !imem_req; i++) @(negedge CLK);
    if (!imem_req) chk("req_timeout", 0, 1);
  endtask

  task automatic fetch_one(input int gd, input int rd, input int hold, input logic [2:0] src,
                           input logic [31:0] tgt, input bit spurious);
    logic [31:0] w;
    w = mem_word(exp_pc);
    wait_req();
    for (int k = 0; k <= gd; k++) begin
      chk("fetch_req", {31'b0, imem_req}, 1);
      chk("fetch_addr", imem_addr, exp_pc);
      ir_ready = 1'($urandom);
      pcSource = 3'($urandom);
      imem_gnt = (k == gd);
      @(negedge CLK);
    end
    imem_gnt = 0;
    chk("wait_req", {31'b0, imem_req}, 0);
    for (int k = 1; k <= rd; k++) begin
      imem_rvalid = (k == rd);
      imem_rdata  = (k == rd) ? w : $urandom;
      @(negedge CLK);
      if (k < rd) chk("wait_valid", {31'b0, ir_valid}, 0);
    end
    imem_rvalid = 0;
    ir_ready = 0;
    chk("cap_valid", {31'b0, ir_valid}, 1);
    chk("cap_ir", ir, w);
    chk("cap_pc", pc, exp_pc);
    chk("pc_plus4", pc_plus4, exp_pc + 32'd4);
    for (int k = 0; k < hold; k++) begin
      pcSource = 3'($urandom);
      jalr_target = $urandom;
      imem_rvalid = spurious | 1'($urandom);
      imem_rdata = $urandom;
      @(negedge CLK);
      chk("hold_valid", {31'b0, ir_valid}, 1);
      chk("hold_ir", ir, w);
      chk("hold_pc", pc, exp_pc);
      chk("hold_req", {31'b0, imem_req}, 0);
    end
    imem_rvalid = 0;
    jalr_target = $urandom; branch_target = $urandom; jal_target = $urandom;
    mtvec = $urandom; mepc = $urandom;
    case (src)
      1: jalr_target = tgt;
      2: branch_target = tgt;
      3: jal_target = tgt;
      4: mtvec = tgt;
      5: mepc = tgt;
      default: ;
    endcase
    pcSource = src;
    ir_ready = 1;
    exp_pc = model_next(src, exp_pc);
    @(negedge CLK);
    ir_ready = 0;
    pcSource = 3'($urandom);
    chk("acc_valid", {31'b0, ir_valid}, 0);
    chk("acc_req", {31'b0, imem_req}, 1);
    chk("acc_pc", pc, exp_pc);
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    chk("rst_pc", pc, 32'h0);
    chk("rst_ir", ir, 32'h0000_0013);
    chk("rst_valid", {31'b0, ir_valid}, 0);
    chk("rst_req", {31'b0, imem_req}, 0);
    RST = 0;
    @(negedge CLK);
    chk("bubble_req", {31'b0, imem_req}, 1);
    for (int i = 0; i < 3; i++) fetch_one(0, 1, 0, 0, 0, 0);
    fetch_one(0, 1, 5, 2, 32'h100, 0);
    fetch_one(0, 1, 0, 1, 32'h203, 0);
    fetch_one(0, 1, 0, 3, 32'h40, 0);
    fetch_one(0, 1, 0, 4, 32'h80, 0);
    fetch_one(0, 1, 0, 3, 32'hFFFF_FFFC, 0);
    fetch_one(0, 1, 0, 0, 0, 0);
    fetch_one(4, 3, 3, 6, 0, 1);
    for (int i = 0; i < 40; i++)
      fetch_one($urandom_range(0, 3), $urandom_range(1, 3), $urandom_range(0, 2),
                3'($urandom), $urandom, 0);
    fetch_one(0, 1, 0, 5, 32'h500, 0);
    wait_req();
    chk("abort_addr", imem_addr, 32'h500);
    imem_gnt = 1;
    @(negedge CLK);
    imem_gnt = 0;
    #2 RST = 1;
    #1;
    chk("abort_pc", pc, 32'h0);
    chk("abort_valid", {31'b0, ir_valid}, 0);
    chk("abort_req", {31'b0, imem_req}, 0);
    @(negedge CLK);
    RST = 0;
    exp_pc = 0;
    fetch_one(0, 1, 0, 0, 0, 0);
    fetch_one(1, 2, 1, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
